// File: rtl/uplink_service_scheduler.sv
// rtl/uplink_service_scheduler.sv - round-robin burst scheduler for four uplink service I/Q channels
// Optional per-channel transfer counters: define UPLINK_SCHED_STATS_EN.
module uplink_service_scheduler #(
  parameter int DW        = 16,
  parameter int NCH       = 4,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en_mask,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_i,
  input  logic [NCH*DW-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_i,
  output logic [DW-1:0]     out_q,
  output logic [1:0]        out_ch,
  output logic [NCH-1:0]    grant,
  output logic              busy
`ifdef UPLINK_SCHED_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NCH*32-1:0] stat_cnt
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [1:0]     sel;
  logic [1:0]     rr_ptr;
  logic [7:0]     burst_cnt;
  logic [NCH-1:0] req;
  logic [1:0]     pick;
  logic           sel_ok;
  logic           can_take;
  logic           xfer;
  logic           last;

  assign req      = in_valid & en_mask;
  assign sel_ok   = in_valid[sel] & en_mask[sel];
  assign can_take = !out_valid | out_ready;
  assign xfer     = (state == GRANT) & sel_ok & can_take;
  assign last     = (burst_cnt == 8'(BURST_LEN - 1));

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  // A masked-off granted channel sees ready low in the cycle it is released.
  always_comb begin
    in_ready = '0;
    if (state == GRANT && en_mask[sel]) in_ready[sel] = can_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_ch    <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_i     <= in_i[sel*DW +: DW];
        out_q     <= in_q[sel*DW +: DW];
        out_ch    <= sel;
        burst_cnt <= burst_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            sel       <= pick;
            grant     <= NCH'(1) << pick;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (!sel_ok || (xfer && last)) begin
            state  <= IDLE;
            rr_ptr <= sel + 2'd1;
            grant  <= '0;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UPLINK_SCHED_STATS_EN
  logic [31:0] cnt [NCH];

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int n = 0; n < NCH; n++) cnt[n] <= '0;
    end else if (xfer) begin
      cnt[sel] <= cnt[sel] + 32'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) stat_cnt[n*32 +: 32] = cnt[n];
  end
`endif

endmodule

// File: tb/tb_uplink_service_scheduler.sv
// tb/tb_uplink_service_scheduler.sv - directed scoreboard bench for uplink_service_scheduler
module tb_uplink_service_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_mask;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] in_i;
  logic [63:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic [1:0]  out_ch;
  logic [3:0]  grant;
  logic        busy;
`ifdef UPLINK_SCHED_STATS_EN
  logic         stat_clr;
  logic [127:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  uplink_service_scheduler #(.DW(16), .NCH(4), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q), .out_ch(out_ch), .grant(grant), .busy(busy)
`ifdef UPLINK_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] i;
    logic [15:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sent[4]    = '{0, 0, 0, 0};
  int   avail[4]   = '{0, 0, 0, 0};
  int   exp_idx[4] = '{0, 0, 0, 0};
  bit   chk_en = 1'b1;
  int   b0, b1, b3, b2;

  function automatic logic [15:0] smp_i(input int ch, input int k);
    return {2'(ch), 2'b01, 12'(k)};
  endfunction

  function automatic logic [15:0] smp_q(input int ch, input int k);
    logic [15:0] v;
    v = smp_i(ch, k);
    return {v[7:0], v[15:8]} ^ 16'h0ff0;
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      in_valid[n]       = sent[n] < avail[n];
      in_i[n*16 +: 16]  = smp_i(n, sent[n]);
      in_q[n*16 +: 16]  = smp_q(n, sent[n]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{2'(ch), smp_i(ch, exp_idx[ch]), smp_q(ch, exp_idx[ch])});
      exp_idx[ch]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Handshakes are sampled at the edge and applied just after it.
  task automatic drive_loop();
    logic [3:0] f;
    logic       r;
    forever begin
      @(posedge clk);
      f = in_valid & in_ready;
      r = rst;
      #1;
      if (!r) for (int n = 0; n < 4; n++) if (f[n]) sent[n]++;
    end
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && chk_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_ch), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_i", 32'(out_i), 32'(e.i));
          chk("out_q", 32'(out_q), 32'(e.q));
        end
      end
    end
  endtask

  task automatic wait_drain(input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      tick();
      c++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_sent(input int ch, input int target, input int bound);
    int c = 0;
    while (sent[ch] < target && c < bound) begin
      tick();
      c++;
    end
    chk("wait_sent", 32'(sent[ch]), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    en_mask = 4'hf;
    out_ready = 1'b1;
`ifdef UPLINK_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    fork
      drive_loop();
      mon_loop();
    join_none

    // reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_i", 32'(out_i), 32'd0);
    rst = 1'b0;

    // round robin, all four channels, two bursts each
    for (int n = 0; n < 4; n++) avail[n] = sent[n] + 16;
    for (int r = 0; r < 2; r++) for (int n = 0; n < 4; n++) push_exp(n, 8);
    tick();
    chk("rr_grant0", 32'(grant), 32'd1);
    chk("rr_busy", 32'(busy), 32'd1);
    repeat (8) tick();
    chk("rr_release", 32'(grant), 32'd0);
    chk("rr_bubble_busy", 32'(busy), 32'd0);
    tick();
    chk("rr_grant1", 32'(grant), 32'd2);
    wait_drain(200);

    // idle release: park rr_ptr at 2, then ch2 (3 samples) against ch1
    push_exp(1, 1);
    avail[1] = sent[1] + 1;
    wait_drain(50);
    push_exp(2, 3);
    push_exp(1, 4);
    avail[2] = sent[2] + 3;
    avail[1] = sent[1] + 4;
    tick();
    chk("idle_grant_ch2", 32'(grant), 32'd4);
    wait_drain(100);

    // backpressure mid-burst; ch0 offers 10 so the burst limit decides the split
    b0 = sent[0];
    push_exp(0, 10);
    avail[0] = b0 + 10;
    tick();
    repeat (3) tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_out_i", 32'(out_i), 32'(smp_i(0, b0 + 2)));
      chk("bp_out_q", 32'(out_q), 32'(smp_q(0, b0 + 2)));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_grant", 32'(grant), 32'd1);
      chk("bp_sent", 32'(sent[0]), 32'(b0 + 3));
    end
    out_ready = 1'b1;
    wait_sent(0, b0 + 8, 50);
    chk("bp_burst_release", 32'(grant), 32'd0);
    tick();
    chk("bp_regrant", 32'(grant), 32'd1);
    wait_drain(100);

    // enable mask 1010, then drop ch1 mid-burst
    en_mask = 4'b1010;
    b0 = sent[0];
    b1 = sent[1];
    b2 = sent[2];
    b3 = sent[3];
    avail[0] = b0 + 4;
    avail[2] = b2 + 4;
    avail[1] = b1 + 16;
    avail[3] = b3 + 16;
    push_exp(1, 8);
    push_exp(3, 8);
    push_exp(1, 3);
    push_exp(3, 8);
    wait_sent(1, b1 + 11, 100);
    en_mask = 4'b1000;
    #1;
    chk("mask_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mask_release", 32'(grant), 32'd0);
    wait_drain(100);
    chk("mask_ch0_idle", 32'(sent[0]), 32'(b0));
    chk("mask_ch2_idle", 32'(sent[2]), 32'(b2));
    chk("mask_ch1_stop", 32'(sent[1]), 32'(b1 + 11));

    // reset mid-burst, then fresh round from ch0
    en_mask = 4'hf;
    chk_en = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 4; n++) avail[n] = sent[n] + 20;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      avail[n] = sent[n] + 8;
      exp_idx[n] = sent[n];
    end
    for (int n = 0; n < 4; n++) push_exp(n, 8);
    tick();
    chk("post_rst_ch0", 32'(grant), 32'd1);
    wait_drain(200);

`ifdef UPLINK_SCHED_STATS_EN
    for (int n = 0; n < 4; n++) chk("stat_cnt", stat_cnt[n*32 +: 32], 32'd8);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int n = 0; n < 4; n++) chk("stat_clr", stat_cnt[n*32 +: 32], 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
